sdram_addr_gen: RTL and testbench

Parametrised multi-channel SDRAM address generator. It holds one independent address pointer per channel, each bounded by a per-channel base/limit window and advanced by a programmable stride. On reaching its limit, a channel either wraps to its base or stops and flags done. It sits between the frame/stream controllers and the SDRAM command sequencer, replacing the fixed two-pointer (read/write) calculator with an N-channel, strided, bounded unit.

---
 rtl/sdram_pkg.sv | 21 ++
 rtl/sdram_addr_chan.sv | 64 ++++++
 rtl/sdram_addr_gen.sv | 85 ++++++++
 tb/tb_sdram_addr_gen.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared types and defaults for the multi-channel SDRAM address generator.
package sdram_pkg;

  // Default SDRAM word-address width.
  localparam int DEFAULT_ADDR_W = 26;

  // Address type at the default width.
  typedef logic [DEFAULT_ADDR_W-1:0] addr_t;

  // Behaviour of a channel once it advances past its limit.
  typedef enum logic {
    STOP = 1'b0,
    WRAP = 1'b1
  } wrap_mode_e;

  // Map the raw wrap_en input onto the wrap mode.
  function automatic wrap_mode_e to_wrap_mode(input logic i_en);
    return i_en ? WRAP : STOP;
  endfunction

endpackage

// File: rtl/sdram_addr_chan.sv
// One address channel: pointer, window registers, sticky done flag and the
// compare/increment that decides advance, wrap or stop.
module sdram_addr_chan
  import sdram_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int STRIDE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [ADDR_W-1:0]   i_base,
  input  logic [ADDR_W-1:0]   i_limit,
  input  logic                i_enable,
  input  logic [STRIDE_W-1:0] i_stride,
  input  wrap_mode_e          i_wrap_mode,
  output logic [ADDR_W-1:0]   o_ptr,
  output logic                o_done,
  output logic                o_wrap_evt
);

  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_limit;
  logic              r_done;

  logic [ADDR_W:0]   w_next;
  logic              w_fits;
  logic              w_adv;

  // One extra bit keeps ptr+stride from silently wrapping at the top of memory.
  assign w_next = {1'b0, r_ptr} + {{(ADDR_W + 1 - STRIDE_W){1'b0}}, i_stride};
  assign w_fits = (w_next <= {1'b0, r_limit});
  // A zero stride is a no-op: it must never set done nor wrap.
  assign w_adv  = i_enable && !r_done && (i_stride != {STRIDE_W{1'b0}});

  assign o_wrap_evt = w_adv && !w_fits && (i_wrap_mode == WRAP);
  assign o_ptr      = r_ptr;
  assign o_done     = r_done;

  // Channel state: load restarts the window, enable advances, wraps or stops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= {ADDR_W{1'b0}};
      r_base  <= {ADDR_W{1'b0}};
      r_limit <= {ADDR_W{1'b0}};
      r_done  <= 1'b0;
    end else if (i_load) begin
      r_base  <= i_base;
      r_limit <= i_limit;
      r_ptr   <= i_base;
      r_done  <= (i_base > i_limit);
    end else if (w_adv) begin
      if (w_fits) begin
        r_ptr <= w_next[ADDR_W-1:0];
      end else if (i_wrap_mode == WRAP) begin
        r_ptr <= r_base;
      end else begin
        r_done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_addr_gen.sv
// N-channel strided, bounded SDRAM address generator. Holds the shared
// stride/wrap mode, decodes ch_sel, muxes the selected pointer onto addr and
// registers the wrap pulse.
module sdram_addr_gen
  import sdram_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int NUM_CH   = 2,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int STRIDE_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [NUM_CH*ADDR_W-1:0] base_addr,
  input  logic [NUM_CH*ADDR_W-1:0] limit_addr,
  input  logic [STRIDE_W-1:0]      stride,
  input  logic                     wrap_en,
  input  logic [CH_W-1:0]          ch_sel,
  input  logic                     enable,
  output logic [ADDR_W-1:0]        addr,
  output logic [NUM_CH-1:0]        done,
  output logic                     wrap
);

  logic [STRIDE_W-1:0] r_stride;
  wrap_mode_e          r_wrap_mode;
  logic                r_wrap;

  logic [NUM_CH-1:0]   w_en_vec;
  logic [NUM_CH-1:0]   w_wrap_vec;
  logic [NUM_CH-1:0]   w_done_vec;
  logic [ADDR_W-1:0]   w_ptr [NUM_CH];
  logic [ADDR_W-1:0]   w_addr;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    // Load outranks enable, so a same-cycle enable is dropped here.
    assign w_en_vec[g] = enable && !load && (ch_sel == CH_W'(g));

    sdram_addr_chan #(
      .ADDR_W   (ADDR_W),
      .STRIDE_W (STRIDE_W)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .i_load      (load),
      .i_base      (base_addr[g*ADDR_W +: ADDR_W]),
      .i_limit     (limit_addr[g*ADDR_W +: ADDR_W]),
      .i_enable    (w_en_vec[g]),
      .i_stride    (r_stride),
      .i_wrap_mode (r_wrap_mode),
      .o_ptr       (w_ptr[g]),
      .o_done      (w_done_vec[g]),
      .o_wrap_evt  (w_wrap_vec[g])
    );
  end

  // Output mux: an out-of-range ch_sel matches no channel and reads as zero.
  always_comb begin
    w_addr = {ADDR_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      w_addr = (ch_sel == CH_W'(i)) ? w_ptr[i] : w_addr;
    end
  end

  // Shared configuration latched on load, plus the one-cycle wrap pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stride    <= {STRIDE_W{1'b0}};
      r_wrap_mode <= STOP;
      r_wrap      <= 1'b0;
    end else if (load) begin
      r_stride    <= stride;
      r_wrap_mode <= to_wrap_mode(wrap_en);
      r_wrap      <= 1'b0;
    end else begin
      r_wrap      <= |w_wrap_vec;
    end
  end

  assign addr = w_addr;
  assign done = w_done_vec;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_sdram_addr_gen.sv
// Self-checking bench for sdram_addr_gen: directed scenarios plus randomized
// traffic compared against an arithmetic reference model of the channels.
module tb_sdram_addr_gen;

  localparam int AW = 26;
  localparam int NC = 2;
  localparam int SW = 8;
  localparam int CW = 1;
  localparam longint TOP = (64'd1 << AW);

  logic             clk = 1'b0;
  logic             rst;
  logic             load;
  logic [NC*AW-1:0] base_addr;
  logic [NC*AW-1:0] limit_addr;
  logic [SW-1:0]    stride;
  logic             wrap_en;
  logic [CW-1:0]    ch_sel;
  logic             enable;
  logic [AW-1:0]    addr;
  logic [NC-1:0]    done;
  logic             wrap;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  longint m_ptr   [NC];
  longint m_base  [NC];
  longint m_limit [NC];
  bit     m_done  [NC];
  longint m_stride;
  bit     m_wrap_en;
  bit     m_wrap;

  sdram_addr_gen #(
    .ADDR_W   (AW),
    .NUM_CH   (NC),
    .CH_W     (CW),
    .STRIDE_W (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .base_addr  (base_addr),
    .limit_addr (limit_addr),
    .stride     (stride),
    .wrap_en    (wrap_en),
    .ch_sel     (ch_sel),
    .enable     (enable),
    .addr       (addr),
    .done       (done),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_ptr[c] = 0; m_base[c] = 0; m_limit[c] = 0; m_done[c] = 1'b0;
    end
    m_stride = 0; m_wrap_en = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic set_win(input int c, input longint b, input longint l);
    base_addr[c*AW +: AW]  = b[AW-1:0];
    limit_addr[c*AW +: AW] = l[AW-1:0];
  endtask

  // Drive one cycle of stimulus on the current negedge, update the model,
  // and return at the following negedge with enable/load idle.
  task automatic step(input bit ld, input bit en, input int sel);
    longint n;
    bit     w;
    w = 1'b0;
    load = ld; enable = en; ch_sel = CW'(sel);
    if (ld) begin
      for (int c = 0; c < NC; c++) begin
        m_base[c]  = longint'(base_addr[c*AW +: AW]);
        m_limit[c] = longint'(limit_addr[c*AW +: AW]);
        m_ptr[c]   = m_base[c];
        m_done[c]  = (m_base[c] > m_limit[c]);
      end
      m_stride  = longint'(stride);
      m_wrap_en = wrap_en;
    end else if (en && sel < NC && !m_done[sel] && m_stride != 0) begin
      n = m_ptr[sel] + m_stride;
      if (n <= m_limit[sel]) m_ptr[sel] = n;
      else if (m_wrap_en) begin m_ptr[sel] = m_base[sel]; w = 1'b1; end
      else m_done[sel] = 1'b1;
    end
    m_wrap = w;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0; enable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ch_sel = 1'b0; #1;
    checks++; if (addr !== 26'd0) begin failures++; $display("FAIL reset_addr0 got=%0d exp=0", addr); end
    ch_sel = 1'b1; #1;
    checks++; if (addr !== 26'd0) begin failures++; $display("FAIL reset_addr1 got=%0d exp=0", addr); end
    checks++; if (done !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", done); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
  endtask

  task automatic test_independent();
    set_win(0, 300, 3000); set_win(1, 3000, 6000);
    stride = 8'd1; wrap_en = 1'b0;
    step(1'b1, 1'b0, 0);
    repeat (10) step(1'b0, 1'b1, 0);
    repeat (10) step(1'b0, 1'b1, 1);
    ch_sel = 1'b0; #1;
    checks++; if (addr !== 26'd310) begin failures++; $display("FAIL indep_ch0 got=%0d exp=310", addr); end
    ch_sel = 1'b1; #1;
    checks++; if (addr !== 26'd3010) begin failures++; $display("FAIL indep_ch1 got=%0d exp=3010", addr); end
  endtask

  task automatic test_stop();
    set_win(0, 100, 108);
    stride = 8'd4; wrap_en = 1'b0;
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 0); ch_sel = 1'b0; #1;
    checks++; if (addr !== 26'd104) begin failures++; $display("FAIL stop_first got=%0d exp=104", addr); end
    step(1'b0, 1'b1, 0); ch_sel = 1'b0; #1;
    checks++; if (addr !== 26'd108) begin failures++; $display("FAIL stop_second got=%0d exp=108", addr); end
    step(1'b0, 1'b1, 0); ch_sel = 1'b0; #1;
    checks++; if (addr !== 26'd108) begin failures++; $display("FAIL stop_hold got=%0d exp=108", addr); end
    checks++; if (done !== 2'b01) begin failures++; $display("FAIL stop_done got=%b exp=01", done); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL stop_nowrap got=%b exp=0", wrap); end
    repeat (2) step(1'b0, 1'b1, 0);
    ch_sel = 1'b0; #1;
    checks++; if (addr !== 26'd108 || done !== 2'b01) begin
      failures++; $display("FAIL stop_sticky got addr=%0d done=%b exp addr=108 done=01", addr, done);
    end
  endtask

  task automatic test_wrap();
    set_win(0, 100, 108);
    stride = 8'd4; wrap_en = 1'b1;
    step(1'b1, 1'b0, 0);
    repeat (2) step(1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 0); ch_sel = 1'b0; #1;
    checks++; if (addr !== 26'd100) begin failures++; $display("FAIL wrap_addr got=%0d exp=100", addr); end
    checks++; if (wrap !== 1'b1) begin failures++; $display("FAIL wrap_pulse got=%b exp=1", wrap); end
    checks++; if (done[0] !== 1'b0) begin failures++; $display("FAIL wrap_done got=%b exp=0", done[0]); end
    step(1'b0, 1'b0, 0);
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL wrap_one_cycle got=%b exp=0", wrap); end
    // Window narrower than the stride: every enable wraps.
    set_win(0, 50, 52);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 0);
    checks++; if (wrap !== 1'b1) begin failures++; $display("FAIL wrap_b2b_first got=%b exp=1", wrap); end
    step(1'b0, 1'b1, 0);
    checks++; if (wrap !== 1'b1) begin failures++; $display("FAIL wrap_b2b_second got=%b exp=1", wrap); end
  endtask

  task automatic test_priority();
    set_win(0, 100, 108);
    stride = 8'd4; wrap_en = 1'b0;
    step(1'b1, 1'b0, 0);
    repeat (3) step(1'b0, 1'b1, 0);
    checks++; if (done[0] !== 1'b1) begin failures++; $display("FAIL prio_setup_done got=%b exp=1", done[0]); end
    set_win(0, 500, 600);
    step(1'b1, 1'b1, 0); ch_sel = 1'b0; #1;
    checks++; if (addr !== 26'd500) begin failures++; $display("FAIL prio_load_wins got=%0d exp=500", addr); end
    checks++; if (done !== 2'b00) begin failures++; $display("FAIL prio_done_clear got=%b exp=00", done); end
  endtask

  task automatic test_boundaries();
    set_win(0, 20, 10); stride = 8'd1; wrap_en = 1'b0;
    step(1'b1, 1'b0, 0);
    checks++; if (done !== 2'b01) begin failures++; $display("FAIL bound_inverted got=%b exp=01", done); end
    set_win(0, TOP - 2, TOP - 1); stride = 8'd4; wrap_en = 1'b0;
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 0); ch_sel = 1'b0; #1;
    checks++; if (addr !== 26'h3FF_FFFE) begin failures++; $display("FAIL bound_top_addr got=%0d exp=%0d", addr, TOP - 2); end
    checks++; if (done[0] !== 1'b1) begin failures++; $display("FAIL bound_top_done got=%b exp=1", done[0]); end
    set_win(0, 100, 108); stride = 8'd0; wrap_en = 1'b1;
    step(1'b1, 1'b0, 0);
    repeat (5) step(1'b0, 1'b1, 0);
    ch_sel = 1'b0; #1;
    checks++; if (addr !== 26'd100 || done !== 2'b00 || wrap !== 1'b0) begin
      failures++; $display("FAIL bound_stride0 got addr=%0d done=%b wrap=%b exp 100/00/0", addr, done, wrap);
    end
  endtask

  task automatic test_reset_mid();
    set_win(0, 1000, 5000); set_win(1, 2000, 9000);
    stride = 8'd3; wrap_en = 1'b1;
    step(1'b1, 1'b0, 0);
    repeat (4) step(1'b0, 1'b1, 0);
    enable = 1'b1; ch_sel = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (addr !== 26'd0 || done !== 2'b00 || wrap !== 1'b0) begin
      failures++; $display("FAIL reset_mid got addr=%0d done=%b wrap=%b exp 0/00/0", addr, done, wrap);
    end
    model_reset();
    @(negedge clk);
    enable = 1'b0;
    rst = 1'b0;
    ch_sel = 1'b1; #1;
    checks++; if (addr !== 26'd0) begin failures++; $display("FAIL reset_mid_ch1 got=%0d exp=0", addr); end
  endtask

  task automatic test_random();
    longint b;
    longint l;
    int     r;
    bit     ld;
    logic [NC-1:0] ed;
    for (int it = 0; it < 400; it++) begin
      ld = (it == 0) || ($urandom_range(0, 11) == 0);
      if (ld) begin
        for (int c = 0; c < NC; c++) begin
          r = $urandom_range(0, 9);
          if (r == 0) begin
            b = longint'($urandom_range(100, 1000)); l = b - longint'($urandom_range(1, 50));
          end else if (r == 1) begin
            l = TOP - 1 - longint'($urandom_range(0, 3)); b = l - longint'($urandom_range(0, 20));
          end else begin
            b = longint'($urandom_range(0, 32'd67107000)); l = b + longint'($urandom_range(0, 80));
          end
          set_win(c, b, l);
        end
        stride  = SW'($urandom_range(0, 12));
        wrap_en = 1'($urandom_range(0, 1));
      end
      step(ld, 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, NC - 1)));
      for (int c = 0; c < NC; c++) begin
        ch_sel = CW'(c); #1;
        checks++; if (longint'(addr) !== m_ptr[c]) begin
          failures++; $display("FAIL rand_addr it=%0d ch=%0d got=%0d exp=%0d", it, c, addr, m_ptr[c]);
        end
      end
      for (int c = 0; c < NC; c++) ed[c] = m_done[c];
      checks++; if (done !== ed) begin failures++; $display("FAIL rand_done it=%0d got=%b exp=%b", it, done, ed); end
      checks++; if (wrap !== m_wrap) begin failures++; $display("FAIL rand_wrap it=%0d got=%b exp=%b", it, wrap, m_wrap); end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; enable = 1'b0; ch_sel = 1'b0;
    base_addr = '0; limit_addr = '0; stride = 8'd0; wrap_en = 1'b0;
    test_reset();
    test_independent();
    test_stop();
    test_wrap();
    test_priority();
    test_boundaries();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
